mem_stage: RTL and testbench

- Memory-access stage of the 5-stage RISC-V core, directly downstream of the EX/MEM pipeline register.
- Non-memory instructions pass through unchanged.
- For loads and stores, the block:
  - runs a registered request/acknowledge transaction on the data-memory bus;
  - stalls the pipeline until the transaction completes;
  - aligns and extends load data;
  - generates store byte enables.
- Results are registered into the MEM/WB outputs, so this block also acts as the MEM/WB pipeline register.

---
 rtl/mem_stage_pkg.sv | 25 ++
 rtl/mem_align.sv | 49 ++++
 rtl/mem_stage.sv | 135 +++++++++++++
 tb/tb_mem_stage.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM stage: load/store one-hot flags, FSM states, reset/zero constants.
package mem_stage_pkg;
    localparam int          XLEN       = 32;
    localparam logic        RST_ENABLE = 1'b1;
    localparam logic [31:0] ZERO_32BIT = 32'h0000_0000;

    localparam logic [4:0] NO_LOAD   = 5'b00000;
    localparam logic [4:0] LOAD_LB   = 5'b00001;
    localparam logic [4:0] LOAD_LH   = 5'b00010;
    localparam logic [4:0] LOAD_LW   = 5'b00100;
    localparam logic [4:0] LOAD_LBU  = 5'b01000;
    localparam logic [4:0] LOAD_LHU  = 5'b10000;

    localparam logic [3:0] NO_STORE  = 4'b0000;
    localparam logic [3:0] STORE_SB  = 4'b0001;
    localparam logic [3:0] STORE_SH  = 4'b0010;
    localparam logic [3:0] STORE_SW  = 4'b0100;
    localparam logic [3:0] STORE_RSV = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;
endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane logic: store enables/replicated data and load extraction/extension.
module mem_align #(
    parameter int XLEN = 32
) (
    input  logic [1:0]      offset,
    input  logic [4:0]      load_flag,
    input  logic [3:0]      store_flag,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data
);
    import mem_stage_pkg::*;

    logic [XLEN-1:0] byte_sh, half_sh;
    logic [7:0]      lb;
    logic [15:0]     lh;

    assign byte_sh = rdata >> {offset, 3'b000};
    assign half_sh = rdata >> {offset[1], 4'b0000};
    assign lb      = byte_sh[7:0];
    assign lh      = half_sh[15:0];

    // A load wins over a simultaneous store flag, so it owns the lane enables.
    always_comb begin
        be    = 4'b0000;
        wdata = store_data;
        if (load_flag != NO_LOAD) begin
            be = 4'b1111;
        end else if (store_flag[0]) begin
            be    = 4'b0001 << offset;
            wdata = {4{store_data[7:0]}};
        end else if (store_flag[1]) begin
            be    = 4'b0011 << {offset[1], 1'b0};
            wdata = {2{store_data[15:0]}};
        end else if (store_flag[2]) begin
            be = 4'b1111;
        end
    end

    always_comb begin
        load_data = rdata;
        if (load_flag[0])      load_data = {{(XLEN-8){lb[7]}}, lb};
        else if (load_flag[1]) load_data = {{(XLEN-16){lh[15]}}, lh};
        else if (load_flag[3]) load_data = {{(XLEN-8){1'b0}}, lb};
        else if (load_flag[4]) load_data = {{(XLEN-16){1'b0}}, lh};
    end
endmodule

// File: rtl/mem_stage.sv
// RISC-V MEM stage and MEM/WB register with a req/ack data-memory FSM.
// Optional MEM_MISALIGN_CHECK_EN traps misaligned halfword/word accesses instead of issuing them.
module mem_stage #(
    parameter int XLEN           = 32,
    parameter int XREG_ADDRWIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [XLEN-1:0]           rd_in,
    input  logic                      rd_en_in,
    input  logic [XREG_ADDRWIDTH-1:0] rd_addr_in,
    input  logic [4:0]                load_flag_in,
    input  logic [3:0]                store_flag_in,
    input  logic [XLEN-1:0]           store_data_in,
    output logic                      stall_req,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [XLEN-1:0]           dmem_addr,
    output logic [3:0]                dmem_be,
    output logic [XLEN-1:0]           dmem_wdata,
    input  logic                      dmem_ack,
    input  logic [XLEN-1:0]           dmem_rdata,
    output logic [XLEN-1:0]           rd_out,
    output logic                      rd_en_out,
    output logic [XREG_ADDRWIDTH-1:0] rd_addr_out,
    output logic                      misalign_err
);
    import mem_stage_pkg::*;

    mem_state_t      state, state_next;
    logic [1:0]      a, off_q, align_off;
    logic [4:0]      load_q, align_load;
    logic [XLEN-1:0] load_data_q, align_load_data, align_wdata;
    logic [3:0]      align_be;
    logic            is_load, mem_op, misalign, misalign_hit, issue;

    assign a       = rd_in[1:0];
    assign is_load = (load_flag_in != NO_LOAD);
    assign mem_op  = is_load || (store_flag_in != NO_STORE);

`ifdef MEM_MISALIGN_CHECK_EN
    logic half_op, word_op;
    assign half_op  = is_load ? ((load_flag_in & (LOAD_LH | LOAD_LHU)) != NO_LOAD)
                              : store_flag_in[1];
    assign word_op  = is_load ? load_flag_in[2] : store_flag_in[2];
    assign misalign = (half_op && a[0]) || (word_op && (a != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign misalign_hit = (state == IDLE) && mem_op && misalign;
    assign issue        = (state == IDLE) && mem_op && !misalign;
    assign stall_req    = issue || (state == WAIT);

    // While waiting, extract with the offset/type latched at issue, not the live inputs.
    assign align_off  = (state == IDLE) ? a : off_q;
    assign align_load = (state == IDLE) ? load_flag_in : load_q;

    mem_align #(.XLEN(XLEN)) u_align (
        .offset     (align_off),
        .load_flag  (align_load),
        .store_flag (store_flag_in),
        .store_data (store_data_in),
        .rdata      (dmem_rdata),
        .be         (align_be),
        .wdata      (align_wdata),
        .load_data  (align_load_data)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue) state_next = WAIT;
            WAIT:    if (dmem_ack) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) state <= IDLE;
        else                   state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= XLEN'(ZERO_32BIT);
            dmem_be     <= 4'b0000;
            dmem_wdata  <= XLEN'(ZERO_32BIT);
            off_q       <= 2'b00;
            load_q      <= NO_LOAD;
            load_data_q <= XLEN'(ZERO_32BIT);
        end else begin
            if (issue) begin
                dmem_req   <= 1'b1;
                dmem_we    <= !is_load;
                dmem_addr  <= {rd_in[XLEN-1:2], 2'b00};
                dmem_be    <= align_be;
                dmem_wdata <= align_wdata;
                off_q      <= a;
                load_q     <= load_flag_in;
            end else if ((state == WAIT) && dmem_ack) begin
                dmem_req <= 1'b0;
                dmem_we  <= 1'b0;
                if (load_q != NO_LOAD) load_data_q <= align_load_data;
            end
        end
    end

    // MEM/WB register: a bubble whenever the stage is stalled or traps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            rd_out      <= XLEN'(ZERO_32BIT);
            rd_en_out   <= 1'b0;
            rd_addr_out <= '0;
        end else if (stall_req || misalign_hit) begin
            rd_en_out <= 1'b0;
        end else begin
            rd_out      <= ((state == DONE) && (load_q != NO_LOAD)) ? load_data_q : rd_in;
            rd_en_out   <= rd_en_in;
            rd_addr_out <= rd_addr_in;
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) misalign_err <= 1'b0;
        else                   misalign_err <= misalign_hit;
    end
`else
    assign misalign_err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads, stores, reset mid-transaction, misaligned word.
module tb_mem_stage;
    logic        clk, rst;
    logic [31:0] rd_in, store_data_in, dmem_addr, dmem_wdata, dmem_rdata, rd_out;
    logic        rd_en_in, stall_req, dmem_req, dmem_we, dmem_ack, rd_en_out, misalign_err;
    logic [4:0]  rd_addr_in, rd_addr_out, load_flag_in;
    logic [3:0]  store_flag_in, dmem_be;

    int checks = 0;
    int failures = 0;
    int stall_cnt = 0;
    int en_cnt = 0;

    mem_stage dut (
        .clk(clk), .rst(rst), .rd_in(rd_in), .rd_en_in(rd_en_in), .rd_addr_in(rd_addr_in),
        .load_flag_in(load_flag_in), .store_flag_in(store_flag_in), .store_data_in(store_data_in),
        .stall_req(stall_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .rd_out(rd_out), .rd_en_out(rd_en_out), .rd_addr_out(rd_addr_out),
        .misalign_err(misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Sample stall before the edge, writeback enable after it.
    task automatic step();
        #1;
        if (stall_req) stall_cnt++;
        @(posedge clk);
        #1;
        if (rd_en_out) en_cnt++;
    endtask

    task automatic nop();
        rd_in = 32'h0; rd_en_in = 1'b0; rd_addr_in = 5'd0;
        load_flag_in = 5'b0; store_flag_in = 4'b0; store_data_in = 32'h0;
    endtask

    task automatic run_load(input string tag, input logic [31:0] addr, input logic [4:0] flag,
                            input logic [31:0] rdata, input logic [31:0] exp_addr,
                            input logic [31:0] exp);
        rd_in = addr; load_flag_in = flag; rd_en_in = 1'b1; rd_addr_in = 5'd9;
        step();
        check({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
        check({tag, "_addr"}, dmem_addr, exp_addr);
        dmem_ack = 1'b1; dmem_rdata = rdata;
        step();
        dmem_ack = 1'b0;
        step();
        check({tag, "_data"}, rd_out, exp);
        check({tag, "_en"}, {31'd0, rd_en_out}, 32'd1);
        nop();
        step();
    endtask

    initial begin
        rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        nop();
        #2;
        check("rst_req", {31'd0, dmem_req}, 32'd0);
        check("rst_be", {28'd0, dmem_be}, 32'd0);
        check("rst_rd_out", rd_out, 32'd0);
        check("rst_rd_en", {31'd0, rd_en_out}, 32'd0);
        check("rst_stall", {31'd0, stall_req}, 32'd0);
        check("rst_misalign", {31'd0, misalign_err}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // ALU pass-through
        rd_in = 32'h0000_1234; rd_en_in = 1'b1; rd_addr_in = 5'd5;
        stall_cnt = 0;
        step();
        check("add_rd_out", rd_out, 32'h0000_1234);
        check("add_rd_en", {31'd0, rd_en_out}, 32'd1);
        check("add_rd_addr", {27'd0, rd_addr_out}, 32'd5);
        check("add_stall_cnt", stall_cnt, 32'd0);
        nop();
        step();

        // LB at 0x103, two WAIT cycles
        stall_cnt = 0; en_cnt = 0;
        rd_in = 32'h0000_0103; load_flag_in = 5'b00001; rd_en_in = 1'b1; rd_addr_in = 5'd7;
        #1 check("lb_stall_idle", {31'd0, stall_req}, 32'd1);
        step();
        check("lb_req", {31'd0, dmem_req}, 32'd1);
        check("lb_addr", dmem_addr, 32'h0000_0100);
        check("lb_be", {28'd0, dmem_be}, 32'hF);
        check("lb_we", {31'd0, dmem_we}, 32'd0);
        step();
        check("lb_req_hold", {31'd0, dmem_req}, 32'd1);
        check("lb_addr_hold", dmem_addr, 32'h0000_0100);
        dmem_ack = 1'b1; dmem_rdata = 32'h80FF_0000;
        step();
        dmem_ack = 1'b0;
        check("lb_req_drop", {31'd0, dmem_req}, 32'd0);
        check("lb_stall_done", {31'd0, stall_req}, 32'd0);
        step();
        check("lb_rd_out", rd_out, 32'hFFFF_FF80);
        check("lb_rd_addr", {27'd0, rd_addr_out}, 32'd7);
        nop();
        step();
        check("lb_stall_cnt", stall_cnt, 32'd3);
        check("lb_en_cnt", en_cnt, 32'd1);

        // SH 0xABCD at 0x202, ack in first WAIT cycle
        stall_cnt = 0; en_cnt = 0;
        rd_in = 32'h0000_0202; store_flag_in = 4'b0010; store_data_in = 32'h0000_ABCD;
        step();
        check("sh_addr", dmem_addr, 32'h0000_0200);
        check("sh_be", {28'd0, dmem_be}, 32'hC);
        check("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
        check("sh_we", {31'd0, dmem_we}, 32'd1);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        check("sh_req_drop", {31'd0, dmem_req}, 32'd0);
        step();
        nop();
        step();
        check("sh_stall_cnt", stall_cnt, 32'd2);
        check("sh_en_cnt", en_cnt, 32'd0);

        // SB 0x5A at 0x001
        rd_in = 32'h0000_0001; store_flag_in = 4'b0001; store_data_in = 32'h1234_565A;
        step();
        check("sb_be", {28'd0, dmem_be}, 32'h2);
        check("sb_wdata", dmem_wdata, 32'h5A5A_5A5A);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        step();
        nop();
        step();

        run_load("lhu", 32'h0000_0102, 5'b10000, 32'h8001_0000, 32'h0000_0100, 32'h0000_8001);
        run_load("lh",  32'h0000_0102, 5'b00010, 32'h8001_0000, 32'h0000_0100, 32'hFFFF_8001);
        run_load("lbu", 32'h0000_0103, 5'b01000, 32'h80FF_0000, 32'h0000_0100, 32'h0000_0080);
        run_load("lb0", 32'h0000_0100, 5'b00001, 32'h0000_0012, 32'h0000_0100, 32'h0000_0012);

        // Reset while in WAIT
        rd_in = 32'h0000_0300; load_flag_in = 5'b00100; rd_en_in = 1'b1; rd_addr_in = 5'd3;
        step();
        check("rstw_req_before", {31'd0, dmem_req}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rstw_req_async", {31'd0, dmem_req}, 32'd0);
        check("rstw_stall_eq", {31'd0, stall_req}, 32'd1);
        nop();
        @(posedge clk); #1 rst = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        step();
        dmem_ack = 1'b0;
        check("rstw_ack_ignored", {31'd0, dmem_req}, 32'd0);
        check("rstw_stall", {31'd0, stall_req}, 32'd0);
        check("rstw_rd_en", {31'd0, rd_en_out}, 32'd0);

        // LW at 0x101
`ifdef MEM_MISALIGN_CHECK_EN
        rd_in = 32'h0000_0101; load_flag_in = 5'b00100; rd_en_in = 1'b1; rd_addr_in = 5'd4;
        #1 check("mis_stall", {31'd0, stall_req}, 32'd0);
        step();
        check("mis_req", {31'd0, dmem_req}, 32'd0);
        check("mis_err", {31'd0, misalign_err}, 32'd1);
        check("mis_rd_en", {31'd0, rd_en_out}, 32'd0);
        nop();
        step();
        check("mis_err_pulse", {31'd0, misalign_err}, 32'd0);
`else
        run_load("lw_mis", 32'h0000_0101, 5'b00100, 32'h1234_5678, 32'h0000_0100, 32'h1234_5678);
        check("lw_mis_err", {31'd0, misalign_err}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
